// File: rtl/sequenciador_comporta.sv
// -----------------------------------------------------------------------------
// sequenciador_comporta
//
// Gate sequencer between the serial weight-frame receiver and the servo PWM
// datapath. Each BCD weight frame is checked against its [peso_min, peso_max]
// window. CONFIRM_FRAMES consecutive in-range frames open the gate
// automatically, and a rising edge on abrir opens it manually. The gate then
// runs open -> hold -> close through a start/done handshake with the servo,
// with a timeout on every movement.
//
// Optional feature (compile-time macro COMPORTA_FECHA_ANTECIPADO_EN):
//   When defined, a valid out-of-range frame seen while an automatically
//   opened gate is held open starts the close sequence at once.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   enable      in   1 = automatic evaluation of frames allowed
//   new_frame   in   one-cycle pulse, weight fields valid
//   peso_max    in   [7:0] BCD {tens,units}, upper limit (0x00 = auto disabled)
//   peso_min    in   [7:0] BCD {tens,units}, lower limit
//   peso_atual  in   [7:0] BCD {tens,units}, measured weight
//   abrir       in   manual open request, synchronous level
//   mov_done    in   one-cycle pulse from servo, position reached
//   cmd_open    out  servo target, 1 = open position
//   mov_start   out  one-cycle pulse, servo begins movement
//   gate_open   out  1 while the gate is held open
//   busy        out  1 while a sequence is in progress
//   erro        out  1 after a movement timeout (cleared only by reset)
//   erro_bcd    out  sticky, last frame had a nibble > 9
//   db_estado   out  [3:0] state code for the display mux
// -----------------------------------------------------------------------------
module sequenciador_comporta #(
    parameter int CONFIRM_FRAMES = 3,
    parameter int HOLD_CYCLES    = 50000000,
    parameter int TIMEOUT_CYCLES = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       new_frame,
    input  logic [7:0] peso_max,
    input  logic [7:0] peso_min,
    input  logic [7:0] peso_atual,
    input  logic       abrir,
    input  logic       mov_done,
    output logic       cmd_open,
    output logic       mov_start,
    output logic       gate_open,
    output logic       busy,
    output logic       erro,
    output logic       erro_bcd,
    output logic [3:0] db_estado
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        AVALIA   = 3'd1,
        ABRINDO  = 3'd2,
        ABERTA   = 3'd3,
        FECHANDO = 3'd4,
        ERRO     = 3'd5
    } estado_t;

    localparam int CONF_W = $clog2(CONFIRM_FRAMES + 1);
    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [CONF_W-1:0] CONF_TARGET = CONF_W'(CONFIRM_FRAMES);
    localparam logic [CONF_W-1:0] CONF_LAST   = CONF_W'(CONFIRM_FRAMES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(TIMEOUT_CYCLES - 1);

    // Both nibbles must be decimal digits.
    function automatic logic bcd_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    // For valid BCD, an unsigned byte compare is a tens-then-units digit
    // compare, because the tens digit occupies the upper nibble.
    // peso_max == 0 disables the automatic window entirely.
    function automatic logic in_range(input logic [7:0] mx,
                                      input logic [7:0] mn,
                                      input logic [7:0] at);
        return (mx != 8'h00) && (mn <= at) && (at <= mx);
    endfunction

    estado_t           state;
    logic              abrir_q;
    logic [CONF_W-1:0] conf_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        cap_max;
    logic [7:0]        cap_min;
    logic [7:0]        cap_atual;
`ifdef COMPORTA_FECHA_ANTECIPADO_EN
    logic              auto_open;   // current opening came from frame confirmation
`endif

    logic abrir_rise;
    logic frame_bcd_ok;
    logic valid_frame;
    logic frame_in_range;
    logic cap_in_range;

    assign abrir_rise     = abrir & ~abrir_q;
    assign frame_bcd_ok   = bcd_ok(peso_max) && bcd_ok(peso_min) && bcd_ok(peso_atual);
    assign valid_frame    = new_frame && frame_bcd_ok;
    assign frame_in_range = in_range(peso_max, peso_min, peso_atual);
    assign cap_in_range   = in_range(cap_max, cap_min, cap_atual);

    // NOTE: every register here, capture fields included, has a reset value
    // so that the first evaluation after reset never sees X data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mov_start <= 1'b0;
            abrir_q   <= 1'b0;
            erro_bcd  <= 1'b0;
            conf_cnt  <= '0;
            hold_cnt  <= '0;
            to_cnt    <= '0;
            cap_max   <= '0;
            cap_min   <= '0;
            cap_atual <= '0;
`ifdef COMPORTA_FECHA_ANTECIPADO_EN
            auto_open <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments; the default below is overridden
            // by any later assignment in the same cycle (last one wins).
            mov_start <= 1'b0;
            abrir_q   <= abrir;

            // Sticky until the next frame with all-decimal nibbles.
            if (new_frame)
                erro_bcd <= !frame_bcd_ok;

            case (state)
                IDLE: begin
                    if (abrir_rise) begin
                        // Manual open wins; a same-cycle frame is discarded.
                        state     <= ABRINDO;
                        mov_start <= 1'b1;
                        to_cnt    <= '0;
`ifdef COMPORTA_FECHA_ANTECIPADO_EN
                        auto_open <= 1'b0;
`endif
                    end else if (valid_frame && enable) begin
                        state     <= AVALIA;
                        cap_max   <= peso_max;
                        cap_min   <= peso_min;
                        cap_atual <= peso_atual;
                    end
                    if (!enable)
                        conf_cnt <= '0;
                end

                AVALIA: begin
                    if (cap_in_range) begin
                        if (conf_cnt < CONF_TARGET)
                            conf_cnt <= conf_cnt + 1'b1;
                        if (conf_cnt >= CONF_LAST) begin
                            state     <= ABRINDO;
                            mov_start <= 1'b1;
                            to_cnt    <= '0;
`ifdef COMPORTA_FECHA_ANTECIPADO_EN
                            auto_open <= 1'b1;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        conf_cnt <= '0;
                        state    <= IDLE;
                    end
                end

                ABRINDO: begin
                    if (mov_done) begin
                        state    <= ABERTA;
                        hold_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state <= ERRO;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ABERTA: begin
                    if (abrir_rise || (valid_frame && frame_in_range)) begin
                        hold_cnt <= '0;
`ifdef COMPORTA_FECHA_ANTECIPADO_EN
                    end else if (valid_frame && auto_open) begin
                        // Weight left the window while auto-opened: close now.
                        state     <= FECHANDO;
                        mov_start <= 1'b1;
                        to_cnt    <= '0;
`endif
                    end else if (hold_cnt == HOLD_LAST) begin
                        state     <= FECHANDO;
                        mov_start <= 1'b1;
                        to_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                FECHANDO: begin
                    if (mov_done) begin
                        state    <= IDLE;
                        conf_cnt <= '0;
                    end else if (to_cnt == TO_LAST) begin
                        state <= ERRO;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                ERRO: state <= ERRO;

                // NOTE: the unused encodings 6 and 7 fall back to IDLE
                // instead of locking up.
                default: state <= IDLE;
            endcase
        end
    end

    // Level outputs are pure decodes of the state flops; mov_start is a flop.
    assign cmd_open  = (state == ABRINDO) || (state == ABERTA);
    assign gate_open = (state == ABERTA);
    assign busy      = (state == AVALIA) || (state == ABRINDO) ||
                       (state == ABERTA) || (state == FECHANDO);
    assign erro      = (state == ERRO);
    assign db_estado = {1'b0, state};

endmodule

// File: tb/tb_sequenciador_comporta.sv
// -----------------------------------------------------------------------------
// tb_sequenciador_comporta
//
// Directed bench for sequenciador_comporta with CONFIRM_FRAMES=2,
// HOLD_CYCLES=20 and TIMEOUT_CYCLES=30. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_sequenciador_comporta;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       new_frame = 1'b0;
    logic [7:0] peso_max = 8'h00;
    logic [7:0] peso_min = 8'h00;
    logic [7:0] peso_atual = 8'h00;
    logic       abrir = 1'b0;
    logic       mov_done = 1'b0;
    logic       cmd_open;
    logic       mov_start;
    logic       gate_open;
    logic       busy;
    logic       erro;
    logic       erro_bcd;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_err = 0;

    sequenciador_comporta #(
        .CONFIRM_FRAMES(2),
        .HOLD_CYCLES   (20),
        .TIMEOUT_CYCLES(30)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .enable    (enable),
        .new_frame (new_frame),
        .peso_max  (peso_max),
        .peso_min  (peso_min),
        .peso_atual(peso_atual),
        .abrir     (abrir),
        .mov_done  (mov_done),
        .cmd_open  (cmd_open),
        .mov_start (mov_start),
        .gate_open (gate_open),
        .busy      (busy),
        .erro      (erro),
        .erro_bcd  (erro_bcd),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    // All outputs packed: {cmd_open, mov_start, gate_open, busy, erro, erro_bcd, db_estado}
    logic [9:0] outs;
    assign outs = {cmd_open, mov_start, gate_open, busy, erro, erro_bcd, db_estado};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] mx, input logic [7:0] mn, input logic [7:0] at);
        peso_max   = mx;
        peso_min   = mn;
        peso_atual = at;
        new_frame  = 1'b1;
        step();
        new_frame  = 1'b0;
    endtask

    task automatic pulse_done();
        mov_done = 1'b1;
        step();
        mov_done = 1'b0;
    endtask

    initial begin
        int wait_n;
        int async_dly;

        // ---------------- reset state ----------------
        #23;
        check("reset_outputs", 32'(outs), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("idle_after_reset", 32'(db_estado), 32'd0);

        // ---------------- basic auto open / hold / close ----------------
        enable = 1'b1;
        send_frame(8'h50, 8'h20, 8'h35);
        check("t2_avalia1", 32'(db_estado), 32'd1);
        check("t2_busy_avalia", 32'(busy), 32'd1);
        step();
        check("t2_back_idle", 32'(db_estado), 32'd0);
        send_frame(8'h50, 8'h20, 8'h35);
        check("t2_no_start_yet", 32'(mov_start), 32'd0);
        step();
        check("t2_mov_start", 32'(mov_start), 32'd1);
        check("t2_cmd_open", 32'(cmd_open), 32'd1);
        check("t2_abrindo", 32'(db_estado), 32'd2);
        step();
        check("t2_start_pulse_end", 32'(mov_start), 32'd0);
        repeat (4) step();
        pulse_done();
        check("t2_gate_open_first", 32'(gate_open), 32'd1);
        check("t2_aberta", 32'(db_estado), 32'd3);
        repeat (19) step();
        check("t2_gate_open_last", 32'(gate_open), 32'd1);
        step();
        check("t2_fechando", 32'(db_estado), 32'd4);
        check("t2_close_start", 32'(mov_start), 32'd1);
        check("t2_close_cmd", 32'(cmd_open), 32'd0);
        check("t2_gate_closed", 32'(gate_open), 32'd0);
        pulse_done();
        check("t2_idle_end", 32'(db_estado), 32'd0);
        check("t2_not_busy", 32'(busy), 32'd0);

        // ---------------- out-of-range frame resets confirmation ----------------
        send_frame(8'h50, 8'h20, 8'h35);
        step();
        send_frame(8'h50, 8'h20, 8'h60);
        step();
        send_frame(8'h50, 8'h20, 8'h35);
        step();
        check("t3_no_open", 32'(db_estado), 32'd0);
        check("t3_no_start", 32'(mov_start), 32'd0);
        send_frame(8'h50, 8'h20, 8'h35);
        step();
        check("t3_open", 32'(db_estado), 32'd2);
        check("t3_mov_start", 32'(mov_start), 32'd1);
        pulse_done();
        repeat (10) step();
        // In-range frame while open restarts the hold count.
        send_frame(8'h50, 8'h20, 8'h35);
        repeat (19) step();
        check("t3_hold_restarted", 32'(gate_open), 32'd1);
        step();
        check("t3_fechando", 32'(db_estado), 32'd4);
        pulse_done();
        check("t3_idle", 32'(db_estado), 32'd0);

        // ---------------- peso_max = 0 and manual open ----------------
        for (int i = 0; i < 3; i++) begin
            send_frame(8'h00, 8'h00, 8'h00);
            step();
            check("t4_max0_never_opens", 32'(db_estado), 32'd0);
        end
        peso_max   = 8'h50;
        peso_min   = 8'h20;
        peso_atual = 8'h35;
        abrir      = 1'b1;
        new_frame  = 1'b1;
        step();
        new_frame  = 1'b0;
        check("t4_manual_abrindo", 32'(db_estado), 32'd2);
        check("t4_manual_start", 32'(mov_start), 32'd1);
        pulse_done();
        check("t4_aberta", 32'(db_estado), 32'd3);
        repeat (20) step();
        check("t4_fechando", 32'(db_estado), 32'd4);
        pulse_done();
        check("t4_idle", 32'(db_estado), 32'd0);
        abrir = 1'b0;
        step();

        // ---------------- BCD error, then timeout to ERRO ----------------
        send_frame(8'h50, 8'h20, 8'h35);
        step();
        check("t6_bcd_clean", 32'(erro_bcd), 32'd0);
        send_frame(8'h50, 8'h20, 8'h3A);
        check("t6_bcd_set", 32'(erro_bcd), 32'd1);
        check("t6_bcd_ignored", 32'(db_estado), 32'd0);
        step();
        send_frame(8'h50, 8'h20, 8'h30);
        check("t6_bcd_cleared", 32'(erro_bcd), 32'd0);
        check("t6_avalia", 32'(db_estado), 32'd1);
        step();
        // conf_cnt kept its 1 across the bad frame, so this second good frame opens.
        check("t6_counted_opens", 32'(db_estado), 32'd2);
        check("t6_mov_start", 32'(mov_start), 32'd1);
        repeat (29) step();
        check("t5_still_abrindo", 32'(db_estado), 32'd2);
        check("t5_no_erro_yet", 32'(erro), 32'd0);
        step();
        check("t5_erro", 32'(erro), 32'd1);
        check("t5_estado5", 32'(db_estado), 32'd5);
        check("t5_cmd_closed", 32'(cmd_open), 32'd0);
        check("t5_not_busy", 32'(busy), 32'd0);
        abrir = 1'b1;
        send_frame(8'h50, 8'h20, 8'h35);
        pulse_done();
        repeat (5) step();
        check("t5_erro_sticky", 32'(db_estado), 32'd5);
        abrir = 1'b0;

        // ---------------- async reset mid-ABERTA ----------------
        @(negedge clock);
        reset = 1'b0;
        step();
        check("t1_erro_reset", 32'(outs), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        step();
        abrir = 1'b1;
        step();
        check("t1_manual_start", 32'(mov_start), 32'd1);
        abrir = 1'b0;
        step();
        pulse_done();
        check("t1_aberta", 32'(db_estado), 32'd3);
        wait_n    = $urandom_range(1, 15);
        async_dly = $urandom_range(1, 7);
        repeat (wait_n) step();
        #(async_dly);
        reset = 1'b0;
        #1;
        check("t1_async_outputs", 32'(outs), 32'h0);
        @(negedge clock);
        reset = 1'b1;
        step();
        check("t1_resume_idle", 32'(db_estado), 32'd0);
        send_frame(8'h50, 8'h20, 8'h35);
        step();
        send_frame(8'h50, 8'h20, 8'h35);
        step();
        check("t1_resume_open", 32'(db_estado), 32'd2);
        check("t1_resume_start", 32'(mov_start), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
